// File: rtl/sap_pkg.sv
// Shared SAP constants: opcodes, one-hot T-states and control-word bit positions.
// Control word order, MSB first: Cp Ep Lm CE Li Ei La Ea Su Eu Lb Lo.
package sap_pkg;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [5:0] T1 = 6'b000001;
  localparam logic [5:0] T2 = 6'b000010;
  localparam logic [5:0] T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000;
  localparam logic [5:0] T5 = 6'b010000;
  localparam logic [5:0] T6 = 6'b100000;

  localparam int CW_W  = 12;
  localparam int CW_CP = 11;
  localparam int CW_EP = 10;
  localparam int CW_LM = 9;
  localparam int CW_CE = 8;
  localparam int CW_LI = 7;
  localparam int CW_EI = 6;
  localparam int CW_LA = 5;
  localparam int CW_EA = 4;
  localparam int CW_SU = 3;
  localparam int CW_EU = 2;
  localparam int CW_LB = 1;
  localparam int CW_LO = 0;

  typedef logic [CW_W-1:0] ctrl_word_t;

endpackage

// File: rtl/sap_ctrl_seq_if.sv
// Control bus between the sequencer (master) and the bus-attached registers (slave).
// Strobes are valid for the whole cycle and sampled at the edge ending it.
interface sap_ctrl_seq_if;

  logic [3:0] opcode;
  logic       cp;
  logic       ep;
  logic       lm;
  logic       ce;
  logic       li;
  logic       ei;
  logic       la;
  logic       ea;
  logic       su;
  logic       eu;
  logic       lb;
  logic       lo;
  logic       hlt;
  logic [5:0] t_state;

  modport master (
    input  opcode,
    output cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt, t_state
  );

  modport slave (
    output opcode,
    input  cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt, t_state
  );

endinterface

// File: rtl/sap_ring_counter.sv
// Six-state one-hot T-state ring; rotates one position per edge unless held.
// clr forces T1 and overrides hold.
module sap_ring_counter
  import sap_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       hold_i,
  output logic [5:0] t_state_o
);

  logic [5:0] ring_q;
  logic [5:0] ring_d;

  always_comb begin
    ring_d = ring_q;
    if (!hold_i) begin
      ring_d = {ring_q[4:0], ring_q[5]};
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      ring_q <= T1;
    end else begin
      ring_q <= ring_d;
    end
  end

  assign t_state_o = ring_q;

endmodule

// File: rtl/sap_ctrl_seq.sv
// SAP controller-sequencer: decodes T-state and opcode into per-cycle load/enable strobes.
// Strobes are combinational from registered state; HLT in T4 freezes the ring until clr.
module sap_ctrl_seq
  import sap_pkg::*;
(
  input  logic          clk,
  input  logic          clr,
  sap_ctrl_seq_if.master bus
);

  logic [5:0] t_state;
  logic       halted_q;
  logic       halted_d;
  logic       halt_now;
  ctrl_word_t cw;
  ctrl_word_t cw_out;

  assign halt_now = (t_state == T4) && (bus.opcode == OP_HLT) && !halted_q;
  assign halted_d = halted_q | halt_now;

  always_ff @(posedge clk) begin
    if (clr) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  // Holding on halted_d keeps the ring parked at T4 from the HLT edge onward.
  sap_ring_counter u_ring (
    .clk       (clk),
    .clr       (clr),
    .hold_i    (halted_d),
    .t_state_o (t_state)
  );

  always_comb begin
    cw = '0;
    case (t_state)
      T1: begin
        cw[CW_EP] = 1'b1;
        cw[CW_LM] = 1'b1;
      end
      T2: cw[CW_CP] = 1'b1;
      T3: begin
        cw[CW_CE] = 1'b1;
        cw[CW_LI] = 1'b1;
      end
      T4: begin
        case (bus.opcode)
          OP_LDA, OP_ADD, OP_SUB: begin
            cw[CW_EI] = 1'b1;
            cw[CW_LM] = 1'b1;
          end
          OP_OUT: begin
            cw[CW_EA] = 1'b1;
            cw[CW_LO] = 1'b1;
          end
          default: ;
        endcase
      end
      T5: begin
        case (bus.opcode)
          OP_LDA: begin
            cw[CW_CE] = 1'b1;
            cw[CW_LA] = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            cw[CW_CE] = 1'b1;
            cw[CW_LB] = 1'b1;
          end
          default: ;
        endcase
      end
      T6: begin
        if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
          cw[CW_EU] = 1'b1;
          cw[CW_LA] = 1'b1;
        end
      end
      default: ;
    endcase
    // Subtract select is held through the whole execute phase of SUB.
    if (bus.opcode == OP_SUB && (t_state == T4 || t_state == T5 || t_state == T6)) begin
      cw[CW_SU] = 1'b1;
    end
  end

  assign cw_out = (clr || halted_q) ? '0 : cw;

  assign bus.cp      = cw_out[CW_CP];
  assign bus.ep      = cw_out[CW_EP];
  assign bus.lm      = cw_out[CW_LM];
  assign bus.ce      = cw_out[CW_CE];
  assign bus.li      = cw_out[CW_LI];
  assign bus.ei      = cw_out[CW_EI];
  assign bus.la      = cw_out[CW_LA];
  assign bus.ea      = cw_out[CW_EA];
  assign bus.su      = cw_out[CW_SU];
  assign bus.eu      = cw_out[CW_EU];
  assign bus.lb      = cw_out[CW_LB];
  assign bus.lo      = cw_out[CW_LO];
  assign bus.hlt     = !clr && halted_d;
  assign bus.t_state = t_state;

endmodule

// File: tb/tb_sap_ctrl_seq.sv
// Bench for sap_ctrl_seq: directed per-cycle vectors queued by the driver,
// checked mid-cycle by an independent monitor against hand-written strobe tables.
module tb_sap_ctrl_seq;

  logic clk = 1'b0;
  logic clr;

  always #5 clk = ~clk;

  sap_ctrl_seq_if bus ();

  sap_ctrl_seq dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  typedef struct {
    logic [5:0]  t;
    logic [12:0] s;
    int          cyc;
    int          ph;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   tidx;
  logic halted_m;

  // Expected strobes, order Cp Ep Lm CE Li Ei La Ea Su Eu Lb Lo, for T-index 0..5.
  function automatic logic [11:0] exp_cw(input int ti, input logic [3:0] op);
    if (ti == 0) return 12'b0110_0000_0000;
    if (ti == 1) return 12'b1000_0000_0000;
    if (ti == 2) return 12'b0001_1000_0000;
    case (op)
      4'h0: begin
        if (ti == 3) return 12'b0010_0100_0000;
        if (ti == 4) return 12'b0001_0010_0000;
        return 12'b0;
      end
      4'h1: begin
        if (ti == 3) return 12'b0010_0100_0000;
        if (ti == 4) return 12'b0001_0000_0010;
        return 12'b0000_0010_0100;
      end
      4'h2: begin
        if (ti == 3) return 12'b0010_0100_1000;
        if (ti == 4) return 12'b0001_0000_1010;
        return 12'b0000_0010_1100;
      end
      4'hE: begin
        if (ti == 3) return 12'b0000_0001_0001;
        return 12'b0;
      end
      default: return 12'b0;
    endcase
  endfunction

  task automatic step(input logic c, input logic [3:0] op, input int ph);
    exp_t e;
    clr        = c;
    bus.opcode = op;
    e.t   = 6'(1) << tidx;
    e.cyc = cyc;
    e.ph  = ph;
    if (c)                           e.s = 13'b0;
    else if (halted_m)               e.s = {1'b1, 12'b0};
    else if (tidx == 3 && op == 4'hF) e.s = {1'b1, 12'b0};
    else                             e.s = {1'b0, exp_cw(tidx, op)};
    sb_q.push_back(e);
    if (c) begin
      tidx     = 0;
      halted_m = 1'b0;
    end else if (!halted_m) begin
      if (tidx == 3 && op == 4'hF) halted_m = 1'b1;
      else                         tidx = (tidx + 1) % 6;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin : monitor
    exp_t        e;
    logic [12:0] act;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        act = {bus.hlt, bus.cp, bus.ep, bus.lm, bus.ce, bus.li, bus.ei,
               bus.la, bus.ea, bus.su, bus.eu, bus.lb, bus.lo};
        n_cmp++;
        if (bus.t_state !== e.t || act !== e.s) begin
          n_bad++;
          $display("FAIL cycle_vec ph=%0d cyc=%0d: got t=%b hlt+cw=%b, want t=%b hlt+cw=%b",
                   e.ph, e.cyc, bus.t_state, act, e.t, e.s);
        end
        n_cmp++;
        if ($countones({bus.ep, bus.ce, bus.ei, bus.ea, bus.eu}) > 1) begin
          n_bad++;
          $display("FAIL bus_drivers ph=%0d cyc=%0d: got enables ep,ce,ei,ea,eu=%b, want at most one high",
                   e.ph, e.cyc, {bus.ep, bus.ce, bus.ei, bus.ea, bus.eu});
        end
      end
    end
  end

  initial begin : driver
    int drain;
    clr        = 1'b1;
    bus.opcode = 4'h0;
    tidx       = 0;
    halted_m   = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    step(1'b1, 4'h0, 0);
    step(1'b1, 4'h0, 0);

    repeat (12) step(1'b0, 4'h0, 1);
    repeat (6)  step(1'b0, 4'h1, 2);
    repeat (6)  step(1'b0, 4'h2, 3);
    repeat (6)  step(1'b0, 4'hE, 4);

    // clr in T5 of ADD
    repeat (4) step(1'b0, 4'h1, 5);
    step(1'b1, 4'h1, 5);
    repeat (6) step(1'b0, 4'h1, 5);

    // halt, hold, release
    repeat (24) step(1'b0, 4'hF, 6);
    step(1'b1, 4'hF, 6);
    repeat (6) step(1'b0, 4'h0, 6);

    // clr coinciding with the HLT T4 cycle
    repeat (3) step(1'b0, 4'hF, 7);
    step(1'b1, 4'hF, 7);
    repeat (6) step(1'b0, 4'h0, 7);

    for (int o = 0; o < 16; o++) begin
      repeat (6) step(1'b0, 4'(o), 8);
    end
    step(1'b1, 4'h0, 8);
    repeat (2) step(1'b0, 4'h0, 8);

    drain = 0;
    while (sb_q.size() > 0 && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    if (sb_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending entries, want 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sap_ctrl_seq.md
# sap_ctrl_seq

Controller-sequencer for the SAP computer: the initiator of the load/enable protocol that the accumulator, B register, MAR, IR, PC, memory and output register respond to. A six-state one-hot ring counter (T1–T6) is combined with the 4-bit IR opcode to drive, each clock cycle, exactly the load (`l*`) and bus-enable (`e*`) strobes that the bus-attached registers sample on the next rising edge. Sits at the top level beside the W-bus; it has no data path of its own.

## Interface
- Parameters: none. Ring length (6) and opcode width (4) are fixed.
- `clk`  in  1  system clock; all state changes on rising edge.
- `clr`  in  1  synchronous, active-high reset.
- `opcode`  in  4  upper nibble of IR, valid from T4 onward.
- `cp`  out  1  program counter increment.
- `ep`  out  1  PC drives W-bus.
- `lm`  out  1  MAR load.
- `ce`  out  1  RAM drives W-bus.
- `li`  out  1  IR load.
- `ei`  out  1  IR address nibble drives W-bus.
- `la`  out  1  accumulator load.
- `ea`  out  1  accumulator drives W-bus.
- `su`  out  1  ALU subtract select (0 = add).
- `eu`  out  1  ALU drives W-bus.
- `lb`  out  1  B register load.
- `lo`  out  1  output register load.
- `hlt`  out  1  halted; stops the ring.
- `t_state`  out  6  one-hot ring state, bit 0 = T1.

## Operation
- All strobes are active-high and are combinational decodes of the registered `t_state`, `opcode` and the internal halted flag.
- Fetch, independent of opcode: T1 `ep`,`lm`; T2 `cp`; T3 `ce`,`li`.
- LDA (0000): T4 `ei`,`lm`; T5 `ce`,`la`; T6 none.
- ADD (0001): T4 `ei`,`lm`; T5 `ce`,`lb`; T6 `eu`,`la`.
- SUB (0010): as ADD, plus `su`=1 throughout T4–T6.
- OUT (1110): T4 `ea`,`lo`; T5, T6 none.
- HLT (1111): in T4, `hlt`=1 combinationally with all other strobes 0. At that edge the halted flag sets and the ring stays at T4. From then on `hlt`=1, all strobes are 0 and `t_state`=000100 until `clr`.
- Any other opcode is a NOP: no strobes in T4–T6.
- Invariant: at most one of `ep`,`ce`,`ei`,`ea`,`eu` is high in any cycle (single W-bus driver).

## Timing
- Ring advances one state per rising edge, T1→T2→…→T6→T1, unless halted.
- Every instruction takes exactly 6 cycles. HLT takes 4 cycles to reach the halt, then holds.
- A strobe asserted in Tn is sampled by its target register at the edge ending Tn.
- `opcode` is not consumed before T4 (IR loads at the end of T3).
- `clr` high at an edge: `t_state`←000001 and halted←0, overriding the halt and any mid-instruction state. While `clr` is high, all strobes and `hlt` are forced to 0.
- First cycle after `clr` deasserts is T1.
- Reset values: `t_state`=000001, `hlt`=0, all strobes 0.
- Simultaneous `clr` with a T4/HLT cycle: `clr` wins; halted does not set.

## Structure
- Shared package `sap_pkg`:
  - opcode constants `OP_LDA`=4'h0, `OP_ADD`=4'h1, `OP_SUB`=4'h2, `OP_OUT`=4'hE, `OP_HLT`=4'hF;
  - one-hot T-state constants `T1`…`T6`;
  - 12-bit control-word bit indices in order Cp Ep Lm CE Li Ei La Ea Su Eu Lb Lo.
- One sub-module: `sap_ring_counter`, which holds the 6-bit one-hot ring with `clr` and hold inputs.
- Microcode decode stays in `sap_ctrl_seq`.

## Test plan
- Reset, then run with `clr` low for 12 cycles, `opcode`=4'h0 → `t_state` sequence 01,02,04,08,10,20 repeats twice. Strobes per cycle: {ep,lm},{cp},{ce,li},{ei,lm},{ce,la},{}.
- `opcode`=4'h2 → T6 shows `eu`,`la`,`su`=1. `su`=1 in T4 and T5 and 0 in T1–T3. With `opcode`=4'h1, `su` stays 0 in all states.
- `opcode`=4'hE → T4 shows `ea`,`lo` only; T5, T6 show no strobes.
- `opcode`=4'hF → `hlt` rises in cycle 4 and `t_state` holds 000100 for 20 cycles with all strobes 0. Pulsing `clr` for 1 cycle → next cycle T1 with `hlt`=0.
- Assert `clr` during T5 of an ADD → following cycle `t_state`=000001, `la`/`lb` never asserted after the reset edge.
- Sweep all 16 opcodes with an assertion on every cycle → never more than one bus enable high; opcodes 3–D produce no strobes in T4–T6.
